// File: rtl/axi_pkg.sv
// AXI4 encodings and read/write engine FSM states shared by the master engines.
// Both engines import this package so their handshakes stay in lockstep.
package axi_pkg;

   localparam logic [3:0] AXI_ID_DEFAULT      = 4'd0;
   localparam logic [2:0] AXI_SIZE_8B         = 3'b011;
   localparam logic [1:0] AXI_BURST_INCR      = 2'b01;
   localparam logic [3:0] AXI_CACHE_NORM_NCNB = 4'b0010;
   localparam logic [2:0] AXI_PROT_DEFAULT    = 3'b000;
   localparam logic [3:0] AXI_QOS_DEFAULT     = 4'b0000;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RA_WAIT = 3'd1,
      ST_RA      = 3'd2,
      ST_R_WAIT  = 3'd3,
      ST_R       = 3'd4,
      ST_DONE    = 3'd5
   } axi_state_e;

endpackage

// File: rtl/axi_master_rd.sv
// AXI4 master read engine: one INCR burst per rd_start, beats re-timed to the user side
// with a 1-clock latency, and a sticky burst error covering RRESP, RID and RLAST mismatches.
module axi_master_rd
   import axi_pkg::*;
#(
   parameter logic [3:0] M_AXI_ARID    = AXI_ID_DEFAULT,
   parameter logic [2:0] M_AXI_ARSIZE  = AXI_SIZE_8B,
   parameter logic [1:0] M_AXI_ARBURST = AXI_BURST_INCR,
   parameter logic       M_AXI_ARLOCK  = 1'b0,
   parameter logic [3:0] M_AXI_ARCACHE = AXI_CACHE_NORM_NCNB,
   parameter logic [2:0] M_AXI_ARPROT  = AXI_PROT_DEFAULT,
   parameter logic [3:0] M_AXI_ARQOS   = AXI_QOS_DEFAULT
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_start,
   input  logic [29:0] rd_addr,
   input  logic [7:0]  rd_len,
   output logic [63:0] rd_data,
   output logic        rd_data_valid,
   output logic        rd_done,
   output logic        rd_err,
   output logic        rd_ready,
   output logic [3:0]  m_axi_arid,
   output logic [29:0] m_axi_araddr,
   output logic [7:0]  m_axi_arlen,
   output logic [2:0]  m_axi_arsize,
   output logic [1:0]  m_axi_arburst,
   output logic        m_axi_arlock,
   output logic [3:0]  m_axi_arcache,
   output logic [2:0]  m_axi_arprot,
   output logic [3:0]  m_axi_arqos,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   input  logic [3:0]  m_axi_rid,
   input  logic [63:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rlast,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready
);

   axi_state_e  state_q, state_d;
   logic [29:0] araddr_q;
   logic [7:0]  arlen_q;
   logic        arvalid_q;
   logic        rready_q;
   logic [7:0]  beat_cnt_q;
   logic        err_q;
   logic [63:0] rd_data_q;
   logic        rd_data_valid_q;
   logic        rd_done_q;

   logic        r_hs;
   logic        cnt_at_len;
   logic        r_final;
   logic        beat_err;

   assign r_hs       = (state_q == ST_R) & m_axi_rvalid & rready_q;
   assign cnt_at_len = (beat_cnt_q == arlen_q);
   // Either RLAST or the beat count closes the burst, so a misbehaving slave cannot hang us.
   assign r_final    = r_hs & (m_axi_rlast | cnt_at_len);
   assign beat_err   = (m_axi_rresp != AXI_RESP_OKAY) | (m_axi_rid != M_AXI_ARID) |
                       (m_axi_rlast != cnt_at_len);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (rd_start) state_d = ST_RA_WAIT;
         ST_RA_WAIT: state_d = ST_RA;
         ST_RA:      if (arvalid_q && m_axi_arready) state_d = ST_R_WAIT;
         ST_R_WAIT:  state_d = ST_R;
         ST_R:       if (r_final) state_d = ST_DONE;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         araddr_q        <= '0;
         arlen_q         <= '0;
         arvalid_q       <= 1'b0;
         rready_q        <= 1'b0;
         beat_cnt_q      <= '0;
         err_q           <= 1'b0;
         rd_data_q       <= '0;
         rd_data_valid_q <= 1'b0;
         rd_done_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         rd_data_valid_q <= 1'b0;
         rd_done_q       <= 1'b0;
         case (state_q)
            ST_RA_WAIT: begin
               araddr_q  <= rd_addr;
               arlen_q   <= rd_len;
               arvalid_q <= 1'b1;
            end
            ST_RA: if (m_axi_arready) arvalid_q <= 1'b0;
            ST_R_WAIT: begin
               rready_q   <= 1'b1;
               beat_cnt_q <= '0;
               err_q      <= 1'b0;
            end
            ST_R: if (r_hs) begin
               rd_data_q       <= m_axi_rdata;
               rd_data_valid_q <= 1'b1;
               if (beat_err) err_q <= 1'b1;
               if (r_final) rready_q <= 1'b0;
               else         beat_cnt_q <= beat_cnt_q + 8'd1;
            end
            ST_DONE: rd_done_q <= 1'b1;
            default: ;
         endcase
      end
   end

   assign rd_data       = rd_data_q;
   assign rd_data_valid = rd_data_valid_q;
   assign rd_done       = rd_done_q;
   assign rd_err        = err_q;
   assign rd_ready      = (state_q == ST_IDLE);

   assign m_axi_arid    = M_AXI_ARID;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arlen   = arlen_q;
   assign m_axi_arsize  = M_AXI_ARSIZE;
   assign m_axi_arburst = M_AXI_ARBURST;
   assign m_axi_arlock  = M_AXI_ARLOCK;
   assign m_axi_arcache = M_AXI_ARCACHE;
   assign m_axi_arprot  = M_AXI_ARPROT;
   assign m_axi_arqos   = M_AXI_ARQOS;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;

endmodule
